// File: rtl/vlsu_pkg.sv
// -----------------------------------------------------------------------------
// vlsu_pkg
// Shared definitions for the vector/scalar load-store unit (vector_ldst_unit):
//   - state encodings (legacy localparams) and the vlsu_state_t enum built on them
//   - LANE_BYTES(): bytes per lane / memory word
// No ports (package).
// -----------------------------------------------------------------------------
package vlsu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } vlsu_state_t;

  // Byte size of one lane; LANE_W is always a multiple of 8.
  function automatic int unsigned LANE_BYTES(input int unsigned lane_w);
    return lane_w / 32'd8;
  endfunction

endpackage

// File: rtl/vlsu_lane_sel.sv
// -----------------------------------------------------------------------------
// vlsu_lane_sel
// Combinational priority encoder: finds the lowest enabled lane strictly above
// cur_lane.
// Ports:
//   mask       in   LANES   lane enables
//   cur_lane   in   LIDX_W  current lane index
//   next_lane  out  LIDX_W  lowest enabled lane above cur_lane (0 if none)
//   none_left  out  1       no enabled lane above cur_lane
// -----------------------------------------------------------------------------
module vlsu_lane_sel
  import vlsu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0]  mask,
  input  logic [LIDX_W-1:0] cur_lane,
  output logic [LIDX_W-1:0] next_lane,
  output logic              none_left
);

  // Scan from the top down so the last hit is the lowest lane above cur_lane.
  always_comb begin
    next_lane = '0;
    none_left = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if ((i > int'(cur_lane)) && mask[i]) begin
        next_lane = LIDX_W'(i);
        none_left = 1'b0;
      end else begin
        next_lane = next_lane;
        none_left = none_left;
      end
    end
  end

endmodule

// File: rtl/vector_ldst_unit.sv
// -----------------------------------------------------------------------------
// vector_ldst_unit
// MEM-stage load/store unit. Accepts one scalar or LANES-wide vector op,
// serialises the enabled lanes (ascending) into single-word accesses over a
// valid/ready memory port, and stalls the pipeline until the op completes.
//
// Optional feature macro: VLSU_STRIDE_EN
//   defined   : vector lane i address = base + i*op_stride (mod 2^ADDR_W)
//   undefined : lane i address = base + i*LANE_BYTES; op_stride ignored
//
// Ports:
//   clk, reset (async, active-low)
//   op_valid/op_vector/op_store/op_base_addr/op_stride/op_mask/op_wdata : op in
//   stall        : hold pipeline
//   rdata        : assembled load result (registered, held until next load)
//   rdata_valid  : one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request (stable until mem_ready)
//   mem_ready/mem_rdata                : memory response (same-cycle read data)
// -----------------------------------------------------------------------------
module vector_ldst_unit
  import vlsu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic                    op_vector,
  input  logic                    op_store,
  input  logic [ADDR_W-1:0]       op_base_addr,
  input  logic [ADDR_W-1:0]       op_stride,
  input  logic [LANES-1:0]        op_mask,
  input  logic [LANES*LANE_W-1:0] op_wdata,
  output logic                    stall,
  output logic [LANES*LANE_W-1:0] rdata,
  output logic                    rdata_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  input  logic [LANE_W-1:0]       mem_rdata
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] LANE_STEP = ADDR_W'(LANE_BYTES(LANE_W));

  vlsu_state_t             state_r;
  logic [LIDX_W-1:0]       lane_r;
  logic [LANES-1:0]        mask_r;
  logic [ADDR_W-1:0]       base_r;
  logic                    store_r;
  logic [LANES*LANE_W-1:0] wdata_r;
  logic [LANES*LANE_W-1:0] stage_r;
  logic [LANES*LANE_W-1:0] rdata_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [LANE_W-1:0]       mem_wdata_r;

  logic [LANES-1:0]        eff_mask_s;
  logic [LIDX_W-1:0]       above0_lane_s;
  logic                    above0_none_s;
  logic [LIDX_W-1:0]       first_lane_s;
  logic                    first_none_s;
  logic [LIDX_W-1:0]       next_lane_s;
  logic                    next_none_s;
  logic [ADDR_W-1:0]       first_step_s;
  logic [ADDR_W-1:0]       acc_step_s;
  logic [LANES*LANE_W-1:0] next_stage_s;
  logic                    stall_s;

`ifdef VLSU_STRIDE_EN
  logic [ADDR_W-1:0]       stride_r;

  // Scalar ops only ever touch lane 0, so the stride term vanishes for them.
  assign first_step_s = op_stride;
  assign acc_step_s   = stride_r;
`else
  logic                    unused_stride_s;

  assign first_step_s    = LANE_STEP;
  assign acc_step_s      = LANE_STEP;
  assign unused_stride_s = ^op_stride;
`endif

  function automatic logic [ADDR_W-1:0] lane_addr(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] step,
    input logic [LIDX_W-1:0] lane
  );
    return base + (ADDR_W'(lane) * step);
  endfunction

  // A scalar op is lane 0 only, regardless of op_mask.
  assign eff_mask_s = op_vector ? op_mask : LANES'(1'b1);

  // First enabled lane at acceptance: lane 0 itself, else the next above it.
  vlsu_lane_sel #(.LANES(LANES), .LIDX_W(LIDX_W)) u_first_sel (
    .mask      (eff_mask_s),
    .cur_lane  ({LIDX_W{1'b0}}),
    .next_lane (above0_lane_s),
    .none_left (above0_none_s)
  );

  assign first_lane_s = eff_mask_s[0] ? {LIDX_W{1'b0}} : above0_lane_s;
  assign first_none_s = ~eff_mask_s[0] & above0_none_s;

  // Next enabled lane after the one currently being accessed.
  vlsu_lane_sel #(.LANES(LANES), .LIDX_W(LIDX_W)) u_next_sel (
    .mask      (mask_r),
    .cur_lane  (lane_r),
    .next_lane (next_lane_s),
    .none_left (next_none_s)
  );

  // Staging image including the word returned this cycle, so the final lane
  // can be folded straight into rdata on the way into DONE.
  always_comb begin
    next_stage_s = stage_r;
    if ((state_r == ACCESS) && mem_ready && !store_r) begin
      next_stage_s[lane_r*LANE_W +: LANE_W] = mem_rdata;
    end else begin
      next_stage_s = stage_r;
    end
  end

  // Pipeline stall decode; gated by reset so it drops asynchronously.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = op_valid & reset;
      ACCESS:  stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Control FSM, op latch, request registers and load result assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      lane_r      <= '0;
      mask_r      <= '0;
      base_r      <= '0;
      store_r     <= 1'b0;
      wdata_r     <= '0;
      stage_r     <= '0;
      rdata_r     <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
`ifdef VLSU_STRIDE_EN
      stride_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            mask_r  <= eff_mask_s;
            base_r  <= op_base_addr;
            store_r <= op_store;
            wdata_r <= op_wdata;
            stage_r <= '0;
`ifdef VLSU_STRIDE_EN
            stride_r <= op_stride;
`endif
            if (first_none_s) begin
              state_r <= DONE;
              if (!op_store) begin
                rdata_r <= '0;
              end else begin
                rdata_r <= rdata_r;
              end
            end else begin
              state_r     <= ACCESS;
              lane_r      <= first_lane_s;
              mem_addr_r  <= lane_addr(op_base_addr, first_step_s, first_lane_s);
              mem_wdata_r <= op_wdata[first_lane_s*LANE_W +: LANE_W];
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            stage_r <= next_stage_s;
            if (next_none_s) begin
              state_r <= DONE;
              if (!store_r) begin
                rdata_r <= next_stage_s;
              end else begin
                rdata_r <= rdata_r;
              end
            end else begin
              lane_r      <= next_lane_s;
              mem_addr_r  <= lane_addr(base_r, acc_step_s, next_lane_s);
              mem_wdata_r <= wdata_r[next_lane_s*LANE_W +: LANE_W];
            end
          end else begin
            state_r <= ACCESS;
          end
        end
        DONE: begin
          // op_valid seen here still belongs to the completing op.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign stall       = stall_s;
  assign rdata       = rdata_r;
  assign rdata_valid = (state_r == DONE);
  assign mem_req     = (state_r == ACCESS);
  assign mem_we      = (state_r == ACCESS) & store_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_vector_ldst_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_ldst_unit
// Table-driven bench for vector_ldst_unit (LANES=4, LANE_W=32, ADDR_W=32).
// Each table row is one op plus its expected request stream, stall count and
// rdata; a hand-written sequence covers asynchronous reset mid-op.
// Expectations for the wrap-around row follow VLSU_STRIDE_EN.
// -----------------------------------------------------------------------------
module tb_vector_ldst_unit;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 32;
  localparam int DW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_vector = 1'b0;
  logic              op_store = 1'b0;
  logic [ADDR_W-1:0] op_base_addr = '0;
  logic [ADDR_W-1:0] op_stride = '0;
  logic [LANES-1:0]  op_mask = '0;
  logic [DW-1:0]     op_wdata = '0;
  logic              stall;
  logic [DW-1:0]     rdata;
  logic              rdata_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_wdata;
  logic              mem_ready = 1'b0;
  logic [LANE_W-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_ldst_unit #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_vector    (op_vector),
    .op_store     (op_store),
    .op_base_addr (op_base_addr),
    .op_stride    (op_stride),
    .op_mask      (op_mask),
    .op_wdata     (op_wdata),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    string         name;
    logic          vec;
    logic          st;
    logic [31:0]   base;
    logic [31:0]   stride;
    logic [3:0]    mask;
    logic [DW-1:0] wdata;
    int            waits;   // wait cycles before mem_ready per request
    logic [DW-1:0] rd;      // read data per request, request n at [n*32 +: 32]
    int            nreq;
    logic [DW-1:0] ea;      // expected address per request
    logic [DW-1:0] ewd;     // expected store data per request
    int            stalls;
    logic [DW-1:0] erd;     // expected rdata at completion
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic vec, input logic st,
                              input logic [31:0] base, input logic [31:0] stride,
                              input logic [3:0] mask, input logic [DW-1:0] wdata,
                              input int waits, input logic [DW-1:0] rd, input int nreq,
                              input logic [DW-1:0] ea, input logic [DW-1:0] ewd,
                              input int stalls, input logic [DW-1:0] erd);
    vec_t v;
    v.name = name; v.vec = vec; v.st = st; v.base = base; v.stride = stride;
    v.mask = mask; v.wdata = wdata; v.waits = waits; v.rd = rd; v.nreq = nreq;
    v.ea = ea; v.ewd = ewd; v.stalls = stalls; v.erd = erd;
    return v;
  endfunction

  // Drive one op and act as memory; starts on a falling edge.
  task automatic run_vec(input vec_t v);
    int nreq;
    int waitc;
    int stalls;
    bit done;
    logic [ADDR_W-1:0] cur_addr;
    logic [LANE_W-1:0] cur_wd;
    nreq = 0; waitc = 0; stalls = 0; done = 1'b0;
    cur_addr = '0; cur_wd = '0;
    @(negedge clk);
    op_valid = 1'b1; op_vector = v.vec; op_store = v.st; op_base_addr = v.base;
    op_stride = v.stride; op_mask = v.mask; op_wdata = v.wdata;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      mem_ready = 1'b0;
      if (stall) stalls++;
      if (rdata_valid) begin
        done = 1'b1;
        break;
      end
      if (mem_req) begin
        if (waitc == 0) begin
          cur_addr = mem_addr;
          cur_wd   = mem_wdata;
        end else begin
          chk($sformatf("%s stable_addr", v.name), DW'(mem_addr), DW'(cur_addr));
          chk($sformatf("%s stable_wdata", v.name), DW'(mem_wdata), DW'(cur_wd));
        end
        if (waitc == v.waits) begin
          mem_ready = 1'b1;
          if (nreq < 4) begin
            mem_rdata = v.rd[nreq*32 +: 32];
            chk($sformatf("%s addr%0d", v.name, nreq), DW'(mem_addr), DW'(v.ea[nreq*32 +: 32]));
            chk($sformatf("%s we%0d", v.name, nreq), DW'(mem_we), DW'(v.st));
            if (v.st) begin
              chk($sformatf("%s wdata%0d", v.name, nreq), DW'(mem_wdata), DW'(v.ewd[nreq*32 +: 32]));
            end
          end
          nreq++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no rdata_valid within 64 cycles", v.name);
    end
    chk($sformatf("%s rdata", v.name), rdata, v.erd);
    chk($sformatf("%s stall_during_done", v.name), DW'(stall), DW'(1'b0));
    op_valid = 1'b0;
    chk($sformatf("%s nreq", v.name), DW'(nreq), DW'(v.nreq));
    chk($sformatf("%s stalls", v.name), DW'(stalls), DW'(v.stalls));
    @(negedge clk);
    #1;
    chk($sformatf("%s valid_pulse", v.name), DW'(rdata_valid), DW'(1'b0));
    chk($sformatf("%s rdata_hold", v.name), rdata, v.erd);
  endtask

  initial begin
    vec_t sc;
    tbl[0] = mk("scalar_ld", 1'b0, 1'b0, 32'h100, 32'h40, 4'b0110, '0, 0,
                {96'h0, 32'hDEADBEEF}, 1, {96'h0, 32'h100}, '0, 2,
                {96'h0, 32'hDEADBEEF});
    tbl[1] = mk("vec_ld", 1'b1, 1'b0, 32'h200, 32'h4, 4'b1111, '0, 0,
                {32'h44, 32'h33, 32'h22, 32'h11}, 4,
                {32'h20C, 32'h208, 32'h204, 32'h200}, '0, 5,
                {32'h44, 32'h33, 32'h22, 32'h11});
    tbl[2] = mk("vec_st_wait", 1'b1, 1'b1, 32'h300, 32'h4, 4'b1010,
                {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000}, 2,
                '0, 2, {64'h0, 32'h30C, 32'h304}, {64'h0, 32'h44440003, 32'h22220001}, 7,
                {32'h44, 32'h33, 32'h22, 32'h11});
    tbl[3] = mk("vec_ld_nomask", 1'b1, 1'b0, 32'h340, 32'h4, 4'b0000, '0, 0,
                '0, 0, '0, '0, 1, '0);
    tbl[4] = mk("vec_ld_sparse", 1'b1, 1'b0, 32'h400, 32'h4, 4'b0101, '0, 1,
                {64'h0, 32'hBBBB, 32'hAAAA}, 2, {64'h0, 32'h408, 32'h400}, '0, 5,
                {32'h0, 32'hBBBB, 32'h0, 32'hAAAA});
    tbl[5] = mk("vec_st_full", 1'b1, 1'b1, 32'h380, 32'h4, 4'b1111,
                {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 0,
                '0, 4, {32'h38C, 32'h388, 32'h384, 32'h380},
                {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 5,
                {32'h0, 32'hBBBB, 32'h0, 32'hAAAA});
`ifdef VLSU_STRIDE_EN
    tbl[6] = mk("vec_ld_wrap", 1'b1, 1'b0, 32'hFFFFFFF0, 32'h10, 4'b1111, '0, 0,
                {32'h4, 32'h3, 32'h2, 32'h1}, 4,
                {32'h00000020, 32'h00000010, 32'h00000000, 32'hFFFFFFF0}, '0, 5,
                {32'h4, 32'h3, 32'h2, 32'h1});
`else
    tbl[6] = mk("vec_ld_wrap", 1'b1, 1'b0, 32'hFFFFFFF0, 32'h10, 4'b1111, '0, 0,
                {32'h4, 32'h3, 32'h2, 32'h1}, 4,
                {32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0}, '0, 5,
                {32'h4, 32'h3, 32'h2, 32'h1});
`endif
    tbl[7] = mk("scalar_st", 1'b0, 1'b1, 32'h120, 32'h40, 4'b0000,
                {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h5A5A1234}, 0,
                '0, 1, {96'h0, 32'h120}, {96'h0, 32'h5A5A1234}, 2,
                {32'h4, 32'h3, 32'h2, 32'h1});
    sc = mk("scalar_after_reset", 1'b0, 1'b0, 32'h500, 32'h4, 4'b1111, '0, 0,
            {96'h0, 32'hCAFEF00D}, 1, {96'h0, 32'h500}, '0, 2,
            {96'h0, 32'hCAFEF00D});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", DW'(stall), DW'(1'b0));
    chk("reset mem_req", DW'(mem_req), DW'(1'b0));
    chk("reset mem_we", DW'(mem_we), DW'(1'b0));
    chk("reset rdata_valid", DW'(rdata_valid), DW'(1'b0));
    chk("reset mem_addr", DW'(mem_addr), DW'(0));
    chk("reset mem_wdata", DW'(mem_wdata), DW'(0));
    chk("reset rdata", rdata, '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
    end

    // Asynchronous reset during the second ACCESS cycle of a 4-lane load
    @(negedge clk);
    op_valid = 1'b1; op_vector = 1'b1; op_store = 1'b0; op_base_addr = 32'h600;
    op_stride = 32'h4; op_mask = 4'hF; op_wdata = '0;
    @(negedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    #1;
    chk("rst_mid precondition mem_req", DW'(mem_req), DW'(1'b1));
    chk("rst_mid precondition addr", DW'(mem_addr), DW'(32'h604));
    reset = 1'b0;
    #1;
    chk("rst_mid mem_req", DW'(mem_req), DW'(1'b0));
    chk("rst_mid stall", DW'(stall), DW'(1'b0));
    chk("rst_mid rdata", rdata, '0);
    chk("rst_mid mem_we", DW'(mem_we), DW'(1'b0));
    chk("rst_mid mem_addr", DW'(mem_addr), DW'(0));
    chk("rst_mid rdata_valid", DW'(rdata_valid), DW'(1'b0));
    op_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_vec(sc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
